if_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the IF stage of the pipeline: the reading side of the PC register. It samples the current PC, fetches the instruction over a variable-latency request/acknowledge memory port and delivers it to the IF/ID register. It then drives the PC register's write-enable and next value, so the PC advances only when an instruction has been consumed or a branch redirects fetch.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/fetch_hold_buf.sv | 35 +++
 rtl/if_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the IF-stage fetch controller: FSM state encoding,
// default PC increment and reset constants.
package if_fetch_pkg;

  localparam int DEF_PC_STEP = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 2'd0;
  localparam fetch_state_t S_WAIT  = 2'd1;
  localparam fetch_state_t S_HOLD  = 2'd2;
  localparam fetch_state_t S_DRAIN = 2'd3;

  localparam fetch_state_t RST_STATE = S_IDLE;
  localparam logic         RST_VALID = 1'b0;

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture register for an instruction word and its address, used while the
// IF/ID register is stalled. Clear wins over load.
module fetch_hold_buf #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [NB_DATA-1:0] i_instr,
  input  logic [NB_DATA-1:0] i_addr,
  output logic [NB_DATA-1:0] o_instr,
  output logic [NB_DATA-1:0] o_addr
);

  logic [NB_DATA-1:0] instr_q;
  logic [NB_DATA-1:0] addr_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      instr_q <= '0;
      addr_q  <= '0;
    end else if (i_clear) begin
      instr_q <= '0;
      addr_q  <= '0;
    end else if (i_load) begin
      instr_q <= i_instr;
      addr_q  <= i_addr;
    end
  end

  assign o_instr = instr_q;
  assign o_addr  = addr_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues one instruction read at a time, delivers
// it to IF/ID and drives the PC write port. Optional IF_FETCH_PERF_CNT_EN adds
// a delivered-instruction counter on o_fetch_cnt.
module if_fetch_ctrl
  import if_fetch_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_PC,
  output logic               o_PCwrite,
  output logic [NB_DATA-1:0] o_next_PC,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_target,
  output logic               o_imem_req,
  output logic [NB_DATA-1:0] o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [NB_DATA-1:0] i_imem_data,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_instr,
  output logic [NB_DATA-1:0] o_fetch_PC
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [NB_DATA-1:0] o_fetch_cnt
`endif
);

  localparam logic [NB_DATA-1:0] STEP = NB_DATA'(PC_STEP);

  fetch_state_t       state_q, state_d;
  logic [NB_DATA-1:0] addr_q, addr_d;
  logic               valid_q;
  logic [NB_DATA-1:0] instr_q;
  logic [NB_DATA-1:0] fetch_pc_q;

  logic               req;
  logic [NB_DATA-1:0] addr_mux;
  logic               pcwrite;
  logic [NB_DATA-1:0] next_pc;
  logic               deliver;
  logic [NB_DATA-1:0] dlv_instr;
  logic [NB_DATA-1:0] dlv_addr;
  logic               hold_load;
  logic [NB_DATA-1:0] hold_instr;
  logic [NB_DATA-1:0] hold_addr;

  fetch_hold_buf #(
    .NB_DATA (NB_DATA)
  ) u_hold_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (hold_load),
    .i_clear (i_branch_taken),
    .i_instr (i_imem_data),
    .i_addr  (addr_q),
    .o_instr (hold_instr),
    .o_addr  (hold_addr)
  );

  // Redirect is evaluated first in every state so it overrides stall and delivery.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req       = 1'b0;
    addr_mux  = addr_q;
    pcwrite   = 1'b0;
    next_pc   = '0;
    deliver   = 1'b0;
    dlv_instr = '0;
    dlv_addr  = '0;
    hold_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_mux = i_PC;
        if (i_branch_taken) begin
          pcwrite = 1'b1;
          next_pc = i_branch_target;
        end else begin
          req     = 1'b1;
          addr_d  = i_PC;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (i_branch_taken) begin
          pcwrite = 1'b1;
          next_pc = i_branch_target;
          state_d = i_imem_ack ? S_IDLE : S_DRAIN;
        end else if (i_imem_ack) begin
          if (i_stall) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end else begin
            deliver   = 1'b1;
            dlv_instr = i_imem_data;
            dlv_addr  = addr_q;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (i_branch_taken) begin
          pcwrite = 1'b1;
          next_pc = i_branch_target;
          state_d = S_IDLE;
        end else if (!i_stall) begin
          deliver   = 1'b1;
          dlv_instr = hold_instr;
          dlv_addr  = hold_addr;
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The request stays up until memory answers; its data is dropped.
        req = 1'b1;
        if (i_branch_taken) begin
          pcwrite = 1'b1;
          next_pc = i_branch_target;
        end
        if (i_imem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      pcwrite = 1'b1;
      next_pc = dlv_addr + STEP;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= RST_STATE;
      addr_q     <= '0;
      valid_q    <= RST_VALID;
      instr_q    <= '0;
      fetch_pc_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= deliver;
      if (deliver) begin
        instr_q    <= dlv_instr;
        fetch_pc_q <= dlv_addr;
      end
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign o_imem_req  = i_reset & req;
  assign o_imem_addr = i_reset ? addr_mux : '0;
  assign o_PCwrite   = i_reset & pcwrite;
  assign o_next_PC   = i_reset ? next_pc : '0;
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_fetch_PC  = fetch_pc_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [NB_DATA-1:0] fetch_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_cnt_q <= '0;
    end else if (deliver) begin
      fetch_cnt_q <= fetch_cnt_q + NB_DATA'(1);
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level fetch model and a variable-latency memory.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, tgt, idata;
  logic        br, stall, ack;
  logic        o_PCwrite, o_imem_req, o_valid;
  logic [31:0] o_next_PC, o_imem_addr, o_instr, o_fetch_PC;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] o_fetch_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_ctrl #(.NB_DATA(32), .PC_STEP(4)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_PC            (pc),
    .o_PCwrite       (o_PCwrite),
    .o_next_PC       (o_next_PC),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (tgt),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_ack      (ack),
    .i_imem_data     (idata),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_fetch_PC      (o_fetch_PC)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt     (o_fetch_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // memory responder
  bit          mem_pend = 0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = '0;
  int          lat_fix = 1;

  // fetch model: at most one fetch record in flight or held
  bit          have_rec = 0, rec_killed = 0, rec_acked = 0;
  logic [31:0] rec_addr = '0;
  logic        e_valid = 1'b0;
  logic [31:0] e_instr = '0, e_fpc = '0, e_cnt = '0;
  logic        e_req, e_pcw;
  logic [31:0] e_addr, e_npc;
  logic        s_req, s_pcw;
  logic [31:0] s_addr, s_npc;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  task automatic reset_model();
    have_rec = 0; rec_killed = 0; rec_acked = 0; rec_addr = '0;
    e_valid = 1'b0; e_instr = '0; e_fpc = '0; e_cnt = '0;
    mem_pend = 0; mem_lat = 0;
  endtask

  // One clock: apply inputs (at posedge+1), sample combinational outputs at
  // negedge, advance model and memory, return at posedge+1.
  task automatic cycle(input logic b, input logic [31:0] t, input logic st, input logic stray);
    bit          deliver, real_ack, n_have, n_killed, n_acked;
    logic [31:0] n_addr, d_instr, d_addr;
    br = b; tgt = t; stall = st; ack = 1'b0; idata = $urandom; real_ack = 0;
    if (mem_pend) begin
      mem_lat--;
      if (mem_lat == 0) begin
        ack = 1'b1; real_ack = 1; idata = memval(mem_addr); mem_pend = 0;
      end
    end else if (stray) begin
      ack = 1'b1;
    end
    @(negedge clk);
    s_req = o_imem_req; s_addr = o_imem_addr; s_pcw = o_PCwrite; s_npc = o_next_PC;
    n_have = have_rec; n_killed = rec_killed; n_acked = rec_acked; n_addr = rec_addr;
    deliver = 0; d_instr = '0; d_addr = '0;
    e_req = 1'b0; e_addr = pc;
    if (!have_rec) begin
      if (!b) begin
        e_req = 1'b1; n_have = 1; n_addr = pc; n_killed = 0; n_acked = 0;
      end
    end else if (rec_killed) begin
      e_req = 1'b1; e_addr = rec_addr;
      if (ack) n_have = 0;
    end else if (!rec_acked) begin
      e_req = 1'b1; e_addr = rec_addr;
      if (b) begin
        if (ack) n_have = 0; else n_killed = 1;
      end else if (ack) begin
        if (st) n_acked = 1;
        else begin deliver = 1; d_instr = memval(rec_addr); d_addr = rec_addr; n_have = 0; end
      end
    end else begin
      if (b) n_have = 0;
      else if (!st) begin deliver = 1; d_instr = memval(rec_addr); d_addr = rec_addr; n_have = 0; end
    end
    e_pcw = b | deliver;
    e_npc = b ? t : d_addr + 32'd4;
    if (s_req && !mem_pend && !real_ack) begin
      mem_pend = 1; mem_addr = s_addr;
      mem_lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
    end
    @(posedge clk);
    #1;
    if (e_pcw) pc = e_npc;
    have_rec = n_have; rec_killed = n_killed; rec_acked = n_acked; rec_addr = n_addr;
    e_valid = deliver;
    if (deliver) begin e_instr = d_instr; e_fpc = d_addr; e_cnt = e_cnt + 32'd1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = 32'h40; br = 1'b1; tgt = 32'h99; stall = 1'b0; ack = 1'b1; idata = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", o_instr); end
    checks++; if (o_fetch_PC !== 32'h0) begin errors++; $display("FAIL rst_fetch_pc got=%h exp=0", o_fetch_PC); end
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", o_imem_addr); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", o_imem_req); end
    checks++; if (o_PCwrite !== 1'b0) begin errors++; $display("FAIL rst_pcwrite got=%b exp=0", o_PCwrite); end
    checks++; if (o_next_PC !== 32'h0) begin errors++; $display("FAIL rst_next_pc got=%h exp=0", o_next_PC); end
`ifdef IF_FETCH_PERF_CNT_EN
    checks++; if (o_fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got=%h exp=0", o_fetch_cnt); end
`endif
    br = 1'b0; ack = 1'b0; pc = 32'h0;
    reset_model();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    lat_fix = 1;
    for (int k = 0; k < 6; k++) begin
      a = 32'(k / 2 * 4);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (k % 2 == 0) begin
        checks++; if (s_req !== 1'b1 || s_addr !== a) begin errors++; $display("FAIL seq_req k=%0d got=%b/%h exp=1/%h", k, s_req, s_addr, a); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL seq_gap k=%0d got=%b exp=0", k, o_valid); end
      end else begin
        checks++; if (s_pcw !== 1'b1 || s_npc !== a + 32'd4) begin errors++; $display("FAIL seq_pc k=%0d got=%b/%h exp=1/%h", k, s_pcw, s_npc, a + 32'd4); end
        checks++; if (o_valid !== 1'b1 || o_instr !== 32'h1111_0000 + a || o_fetch_PC !== a) begin
          errors++; $display("FAIL seq_dlv k=%0d got=%b/%h/%h exp=1/%h/%h", k, o_valid, o_instr, o_fetch_PC, 32'h1111_0000 + a, a);
        end
      end
    end
  endtask

  task automatic test_stall();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h10) begin errors++; $display("FAIL stall_req got=%b/%h exp=1/00000010", s_req, s_addr); end
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 32'h0, 1'b1, (j == 1));
      checks++; if (s_pcw !== 1'b0) begin errors++; $display("FAIL stall_pcw j=%0d got=%b exp=0", j, s_pcw); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_valid j=%0d got=%b exp=0", j, o_valid); end
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_pcw !== 1'b1 || s_npc !== 32'h14) begin errors++; $display("FAIL stall_rel_pc got=%b/%h exp=1/00000014", s_pcw, s_npc); end
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'h1111_0010 || o_fetch_PC !== 32'h10) begin
      errors++; $display("FAIL stall_rel_dlv got=%b/%h/%h exp=1/11110010/00000010", o_valid, o_instr, o_fetch_PC);
    end
  endtask

  task automatic test_branch_wait();
    lat_fix = 4;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h14) begin errors++; $display("FAIL bw_req got=%b/%h exp=1/00000014", s_req, s_addr); end
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    checks++; if (s_pcw !== 1'b1 || s_npc !== 32'h200) begin errors++; $display("FAIL bw_redirect got=%b/%h exp=1/00000200", s_pcw, s_npc); end
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h14 || s_pcw !== 1'b0) begin
        errors++; $display("FAIL bw_drain j=%0d got=%b/%h/%b exp=1/00000014/0", j, s_req, s_addr, s_pcw);
      end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bw_discard j=%0d got=%b exp=0", j, o_valid); end
    end
    lat_fix = 1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL bw_newreq got=%b/%h exp=1/00000200", s_req, s_addr); end
  endtask

  task automatic test_branch_ack();
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    checks++; if (s_pcw !== 1'b1 || s_npc !== 32'h300) begin errors++; $display("FAIL ba_pc got=%b/%h exp=1/00000300", s_pcw, s_npc); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ba_valid got=%b exp=0", o_valid); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h300) begin errors++; $display("FAIL ba_req got=%b/%h exp=1/00000300", s_req, s_addr); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'h1111_0300 || s_npc !== 32'h304) begin
      errors++; $display("FAIL ba_dlv got=%b/%h/%h exp=1/11110300/00000304", o_valid, o_instr, s_npc);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b0 || s_pcw !== 1'b1) begin errors++; $display("FAIL wrap_idle_br got=%b/%b exp=0/1", s_req, s_pcw); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", s_addr); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_pcw !== 1'b1 || s_npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got=%b/%h exp=1/00000000", s_pcw, s_npc); end
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'h1110_FFFC || o_fetch_PC !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_dlv got=%b/%h/%h exp=1/1110fffc/fffffffc", o_valid, o_instr, o_fetch_PC);
    end
  endtask

  task automatic test_reset_mid();
    lat_fix = 5;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0; pc = 32'h80;
    #1;
    checks++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0) begin errors++; $display("FAIL mid_req got=%b/%h exp=0/0", o_imem_req, o_imem_addr); end
    checks++; if (o_PCwrite !== 1'b0 || o_next_PC !== 32'h0) begin errors++; $display("FAIL mid_pc got=%b/%h exp=0/0", o_PCwrite, o_next_PC); end
    checks++; if (o_valid !== 1'b0 || o_instr !== 32'h0 || o_fetch_PC !== 32'h0) begin
      errors++; $display("FAIL mid_out got=%b/%h/%h exp=0/0/0", o_valid, o_instr, o_fetch_PC);
    end
`ifdef IF_FETCH_PERF_CNT_EN
    checks++; if (o_fetch_cnt !== 32'h0) begin errors++; $display("FAIL mid_cnt got=%h exp=0", o_fetch_cnt); end
`endif
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1; lat_fix = 1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h80) begin errors++; $display("FAIL mid_first got=%b/%h exp=1/00000080", s_req, s_addr); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'h1111_0080) begin errors++; $display("FAIL mid_dlv got=%b/%h exp=1/11110080", o_valid, o_instr); end
`ifdef IF_FETCH_PERF_CNT_EN
    checks++; if (o_fetch_cnt !== 32'h1) begin errors++; $display("FAIL mid_cnt1 got=%h exp=1", o_fetch_cnt); end
`endif
  endtask

  task automatic test_random();
    logic        b, st, sy;
    logic [31:0] t;
    lat_fix = 0;
    for (int i = 0; i < 400; i++) begin
      b  = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 2) == 0);
      sy = ($urandom_range(0, 7) == 0);
      t  = $urandom & 32'hFFFF_FFFC;
      cycle(b, t, st, sy);
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, s_req, e_req); end
      if (e_req) begin
        checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, s_addr, e_addr); end
      end
      checks++; if (s_pcw !== e_pcw) begin errors++; $display("FAIL rnd_pcw i=%0d got=%b exp=%b", i, s_pcw, e_pcw); end
      if (e_pcw) begin
        checks++; if (s_npc !== e_npc) begin errors++; $display("FAIL rnd_npc i=%0d got=%h exp=%h", i, s_npc, e_npc); end
      end
      checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, o_valid, e_valid); end
      checks++; if (o_instr !== e_instr || o_fetch_PC !== e_fpc) begin
        errors++; $display("FAIL rnd_data i=%0d got=%h/%h exp=%h/%h", i, o_instr, o_fetch_PC, e_instr, e_fpc);
      end
`ifdef IF_FETCH_PERF_CNT_EN
      checks++; if (o_fetch_cnt !== e_cnt) begin errors++; $display("FAIL rnd_cnt i=%0d got=%h exp=%h", i, o_fetch_cnt, e_cnt); end
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
